input_port_controller: RTL and testbench

INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

---
 rtl/input_port_controller.sv | 129 ++++++++++++
 tb/tb_input_port_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_controller.sv
// Input port controller: flit FIFO plus wormhole routing FSM driving a 1x4 demux select.
// Optional drop counter enabled by `define FLIT_DROP_COUNT_EN.
module input_port_controller #(
   parameter int flitWidth = 16,
   parameter int fifoDepth = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [flitWidth-1:0] inputFlit,
   input  logic                 inputValid,
   output logic                 inputReady,
   output logic [1:0]           select,
   output logic [flitWidth-1:0] outputFlit,
   output logic                 outputValid,
   input  logic [3:0]           downstreamReady
`ifdef FLIT_DROP_COUNT_EN
   ,
   output logic [7:0]           dropCount
`endif
);

   localparam int PW = $clog2(fifoDepth);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(fifoDepth);

   typedef enum logic {IDLE, ROUTED} state_t;

   logic [flitWidth-1:0] mem_q [fifoDepth];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   state_t               state_q, state_d;
   logic [1:0]           select_q, select_d;

   logic [flitWidth-1:0] front;
   logic [1:0]           ftype;
   logic                 is_head, is_tail;
   logic                 empty, full;
   logic                 push, pop, out_vld;
`ifdef FLIT_DROP_COUNT_EN
   logic                 drop;
   logic [7:0]           drop_q;
`endif

   assign front   = mem_q[rd_ptr_q];
   assign ftype   = front[flitWidth-1 -: 2];
   // 01 = head, 11 = head+tail; bit 1 set marks packet end (10 tail, 11 head+tail)
   assign is_head = ftype[0];
   assign is_tail = ftype[1];
   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign push    = inputValid && !full;

   assign inputReady  = !full;
   assign outputValid = out_vld;
   assign outputFlit  = front;
   assign select      = select_q;

   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      pop      = 1'b0;
      out_vld  = 1'b0;
`ifdef FLIT_DROP_COUNT_EN
      drop     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
               if (is_head) begin
                  select_d = front[1:0];
                  state_d  = ROUTED;
               end else begin
                  pop = 1'b1;
`ifdef FLIT_DROP_COUNT_EN
                  drop = 1'b1;
`endif
               end
            end
         end
         ROUTED: begin
            // head flits seen here are forwarded as body; only a tail releases the lock
            out_vld = !empty;
            if (out_vld && downstreamReady[select_q]) begin
               pop = 1'b1;
               if (is_tail) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         select_q <= 2'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // storage needs no reset: contents are only observed through valid entries
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= inputFlit;
   end

`ifdef FLIT_DROP_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 8'd0;
      end else if (drop && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign dropCount = drop_q;
`endif

endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller (default 16-bit flits, 4-entry FIFO).
module tb_input_port_controller;

   logic        clk;
   logic        rst_n;
   logic [15:0] inputFlit;
   logic        inputValid;
   logic        inputReady;
   logic [1:0]  select;
   logic [15:0] outputFlit;
   logic        outputValid;
   logic [3:0]  downstreamReady;
`ifdef FLIT_DROP_COUNT_EN
   logic [7:0]  dropCount;
`endif

   int total = 0;
   int bad   = 0;

   input_port_controller #(.flitWidth(16), .fifoDepth(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inputFlit       (inputFlit),
      .inputValid      (inputValid),
      .inputReady      (inputReady),
      .select          (select),
      .outputFlit      (outputFlit),
      .outputValid     (outputValid),
      .downstreamReady (downstreamReady)
`ifdef FLIT_DROP_COUNT_EN
      ,
      .dropCount       (dropCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [15:0] pkt [6];
   logic [15:0] got_flit [8];
   logic [1:0]  got_sel [8];
   int          n_got;
   int          k;
   logic        acc;

   initial begin
      rst_n = 1'b0;
      inputFlit = '0;
      inputValid = 1'b0;
      downstreamReady = 4'b0000;
      tick();
      tick();
      check("rst_inputReady", 32'(inputReady), 32'd1);
      check("rst_outputValid", 32'(outputValid), 32'd0);
      check("rst_select", 32'(select), 32'd0);
`ifdef FLIT_DROP_COUNT_EN
      check("rst_dropCount", 32'(dropCount), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // single head+tail flit to port 2
      downstreamReady = 4'b1111;
      inputFlit = 16'hC002; inputValid = 1'b1;
      tick();
      inputValid = 1'b0;
      check("ht_route_latency", 32'(outputValid), 32'd0);
      tick();
      check("ht_select", 32'(select), 32'd2);
      check("ht_valid", 32'(outputValid), 32'd1);
      check("ht_flit", 32'(outputFlit), 32'hC002);
      tick();
      check("ht_done_valid", 32'(outputValid), 32'd0);
      check("ht_select_hold", 32'(select), 32'd2);

      // three-flit packet to port 1, stalled until bit1 of ready rises
      downstreamReady = 4'b0001;
      inputValid = 1'b1;
      inputFlit = 16'h4001; tick();
      inputFlit = 16'h0ABC; tick();
      inputFlit = 16'h8DEF; tick();
      inputValid = 1'b0;
      check("pk_select", 32'(select), 32'd1);
      check("pk_valid_stall", 32'(outputValid), 32'd1);
      check("pk_head_stall", 32'(outputFlit), 32'h4001);
      tick();
      check("pk_head_stable", 32'(outputFlit), 32'h4001);
      check("pk_valid_held", 32'(outputValid), 32'd1);
      downstreamReady = 4'b0010;
      tick();
      check("pk_body", 32'(outputFlit), 32'h0ABC);
      tick();
      check("pk_tail", 32'(outputFlit), 32'h8DEF);
      tick();
      check("pk_done", 32'(outputValid), 32'd0);

      // fill to full with no downstream ready
      downstreamReady = 4'b0000;
      inputValid = 1'b1;
      inputFlit = 16'h4003; tick();
      check("fill1_ready", 32'(inputReady), 32'd1);
      inputFlit = 16'h0111; tick();
      check("fill2_ready", 32'(inputReady), 32'd1);
      inputFlit = 16'h0222; tick();
      check("fill3_ready", 32'(inputReady), 32'd1);
      inputFlit = 16'h0333; tick();
      check("fill4_full", 32'(inputReady), 32'd0);
      inputFlit = 16'h8FFF; tick();
      check("fill5_rejected", 32'(inputReady), 32'd0);
      check("fill_select", 32'(select), 32'd3);
      inputValid = 1'b0;
      downstreamReady = 4'b1000;
      tick();
      check("fill_ready_after_pop", 32'(inputReady), 32'd1);
      check("fill_flit2", 32'(outputFlit), 32'h0111);
      tick();
      tick();
      tick();
      check("fill_no_fifth", 32'(outputValid), 32'd0);
      inputValid = 1'b1; inputFlit = 16'h8444; tick();
      inputValid = 1'b0;
      check("fill_tail_valid", 32'(outputValid), 32'd1);
      check("fill_tail_flit", 32'(outputFlit), 32'h8444);
      tick();
      check("fill_tail_done", 32'(outputValid), 32'd0);

      // orphan body flit is discarded
      downstreamReady = 4'b1111;
      inputValid = 1'b1; inputFlit = 16'h0123; tick();
      inputValid = 1'b0;
      check("orph_valid0", 32'(outputValid), 32'd0);
      tick();
      check("orph_valid1", 32'(outputValid), 32'd0);
      check("orph_ready", 32'(inputReady), 32'd1);
`ifdef FLIT_DROP_COUNT_EN
      check("orph_dropCount1", 32'(dropCount), 32'd1);
`endif
      inputValid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         inputFlit = (i % 2 == 0) ? 16'h0055 : 16'h8066;
         tick();
         if (i == 100) check("orph_stream_valid", 32'(outputValid), 32'd0);
      end
      inputValid = 1'b0;
      tick();
      tick();
      check("orph_after_valid", 32'(outputValid), 32'd0);
      check("orph_after_select", 32'(select), 32'd3);
`ifdef FLIT_DROP_COUNT_EN
      check("orph_dropCount_sat", 32'(dropCount), 32'd255);
`endif

      // reset in the middle of a buffered packet
      downstreamReady = 4'b0000;
      inputValid = 1'b1;
      inputFlit = 16'h4002; tick();
      inputFlit = 16'h0AAA; tick();
      inputFlit = 16'h0BBB; tick();
      inputValid = 1'b0;
      check("mr_valid_before", 32'(outputValid), 32'd1);
      check("mr_select_before", 32'(select), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("mr_valid", 32'(outputValid), 32'd0);
      check("mr_select", 32'(select), 32'd0);
      check("mr_ready", 32'(inputReady), 32'd1);
`ifdef FLIT_DROP_COUNT_EN
      check("mr_dropCount", 32'(dropCount), 32'd0);
`endif
      #1 rst_n = 1'b1;
      tick();
      downstreamReady = 4'b0010;
      inputValid = 1'b1;
      inputFlit = 16'h4001; tick();
      check("mr_latency", 32'(outputValid), 32'd0);
      inputFlit = 16'h8001; tick();
      inputValid = 1'b0;
      check("mr_new_select", 32'(select), 32'd1);
      check("mr_new_head", 32'(outputFlit), 32'h4001);
      tick();
      check("mr_new_tail", 32'(outputFlit), 32'h8001);
      tick();
      check("mr_new_done", 32'(outputValid), 32'd0);

      // back-to-back packets, port 3 then port 0
      downstreamReady = 4'b1111;
      pkt[0] = 16'h4003; pkt[1] = 16'h0A01; pkt[2] = 16'h8A02;
      pkt[3] = 16'h4000; pkt[4] = 16'h0B01; pkt[5] = 16'h8B02;
      n_got = 0;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         if (k < 6) begin
            inputValid = 1'b1;
            inputFlit = pkt[k];
         end else begin
            inputValid = 1'b0;
         end
         acc = inputValid && inputReady;
         if (outputValid && downstreamReady[select] && n_got < 8) begin
            got_flit[n_got] = outputFlit;
            got_sel[n_got] = select;
            n_got++;
         end
         tick();
         if (acc) k++;
      end
      inputValid = 1'b0;
      check("b2b_count", 32'(n_got), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < n_got) begin
            check($sformatf("b2b_flit%0d", i), 32'(got_flit[i]), 32'(pkt[i]));
            check($sformatf("b2b_sel%0d", i), 32'(got_sel[i]), (i < 3) ? 32'd3 : 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
